mod_n_updown_counter: RTL and testbench

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

---
 rtl/mod_n_pkg.sv | 13 +
 rtl/mod_n_wrap_sat.sv | 35 +++
 rtl/mod_n_updown_counter.sv | 99 +++++++++
 tb/tb_mod_n_updown_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_n_pkg.sv
// Shared types for the mod-N up/down counter: FSM states and direction codes.
package mod_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_n_wrap_sat.sv
// Saturating wrap counter: counts terminal-count pulses, sticks at all-ones.
module mod_n_wrap_sat
  import mod_n_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [WRAP_W-1:0] cnt_o
);

  logic [WRAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + WRAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with runtime modulus, load and one-shot mode.
// Define MOD_N_UPDOWN_WRAPCNT_EN to add the saturating wrap_cnt output.
module mod_n_updown_counter
  import mod_n_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              oneshot,
  input  logic              start,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              done
`ifdef MOD_N_UPDOWN_WRAPCNT_EN
  ,
  output logic [WRAP_W-1:0] wrap_cnt
`endif
);

  if (WIDTH < 1 || WRAP_W < 1) begin : g_param_chk
    $error("WIDTH and WRAP_W must be >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             is_up;
  logic             step_ok;
  logic             term;
  logic [WIDTH-1:0] wrap_val;

  assign is_up    = (up == DIR_UP);
  assign step_ok  = en && (!oneshot || state_q == RUN);
  assign term     = is_up ? (out_q == max_val) : (out_q == '0);
  assign wrap_val = is_up ? '0 : max_val;

  always_comb begin
    out_d   = out_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (load) begin
      out_d   = (load_val > max_val) ? max_val : load_val;
      state_d = IDLE;
    end else if (start) begin
      out_d   = wrap_val;
      state_d = RUN;
    end else if (step_ok) begin
      // Out of range after max_val was lowered: snap back without a tc.
      if (out_q > max_val) begin
        out_d = wrap_val;
      end else if (term) begin
        tc_d = 1'b1;
        if (oneshot && state_q == RUN) begin
          state_d = DONE;
        end else begin
          out_d = wrap_val;
        end
      end else begin
        out_d = is_up ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign done = (state_q == DONE);

`ifdef MOD_N_UPDOWN_WRAPCNT_EN
  mod_n_wrap_sat #(
    .WRAP_W (WRAP_W)
  ) u_wrap_sat (
    .clk   (clk),
    .rst   (rst),
    .clr_i (load),
    .inc_i (tc_q),
    .cnt_o (wrap_cnt)
  );
`endif

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: vector table plus corner sequences.
module tb_mod_n_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up, load, oneshot, start;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] out;
  logic         tc, done;
`ifdef MOD_N_UPDOWN_WRAPCNT_EN
  logic [1:0]   wrap_cnt;
`endif

  mod_n_updown_counter #(
    .WIDTH  (W),
    .WRAP_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .oneshot  (oneshot),
    .start    (start),
    .out      (out),
    .tc       (tc),
    .done     (done)
`ifdef MOD_N_UPDOWN_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en, up, load;
    logic [W-1:0] lv, mv;
    logic         os, st;
    logic [W-1:0] eo;
    logic         et, ed;
  } vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic         t, d;
    int           idx;
  } exp_t;

  int   errs = 0;
  int   checks = 0;
  int   vidx = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s #%0d: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  function automatic vec_t V(input logic e, u, l, input int lv, mv,
                             input logic os, st, input int eo,
                             input logic et, ed);
    vec_t v;
    v.en = e; v.up = u; v.load = l;
    v.lv = W'(lv); v.mv = W'(mv);
    v.os = os; v.st = st;
    v.eo = W'(eo); v.et = et; v.ed = ed;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic drive(input vec_t v);
    exp_t e;
    en = v.en; up = v.up; load = v.load;
    load_val = v.lv; max_val = v.mv;
    oneshot = v.os; start = v.st;
    e.o = v.eo; e.t = v.et; e.d = v.ed; e.idx = vidx;
    sb.push_back(e);
    vidx++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", vidx, 1, 0);
    end else begin
      e = sb.pop_front();
      chk("out", e.idx, 32'(out), 32'(e.o));
      chk("tc", e.idx, 32'(tc), 32'(e.t));
      chk("done", e.idx, 32'(done), 32'(e.d));
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 0; up = 1; load = 0; oneshot = 0; start = 0;
    load_val = '0; max_val = 4'd9;
    #2;
    chk("rst_out", 0, 32'(out), 0);
    chk("rst_tc", 0, 32'(tc), 0);
    chk("rst_done", 0, 32'(done), 0);
    #10 rst = 1'b0;

    // Continuous up count, max 9
    for (int i = 1; i <= 12; i++) begin
      tbl.push_back(V(1, 1, 0, 0, 9, 0, 0, i % 10, (i % 10) == 0, 0));
    end
    // Load then count down through zero
    tbl.push_back(V(0, 0, 1, 5, 9, 0, 0, 5, 0, 0));
    for (int i = 4; i >= 0; i--) begin
      tbl.push_back(V(1, 0, 0, 0, 9, 0, 0, i, 0, 0));
    end
    tbl.push_back(V(1, 0, 0, 0, 9, 0, 0, 9, 1, 0));
    // Lowered modulus and clamped load
    tbl.push_back(V(0, 1, 1, 8, 9, 0, 0, 8, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 5, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 1, 12, 5, 0, 0, 5, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 5, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 1, 0, 0, 5, 0, 0, 0, 0, 0));
    // max_val = 0: every step terminal
    tbl.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // One-shot up, max 3: en ignored in IDLE, then run to DONE and hold
    tbl.push_back(V(0, 1, 1, 2, 3, 1, 0, 2, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, 2, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 3, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, i, 0, 0));
    end
    tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, 3, 1, 1));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, 3, 0, 1));
    end
    tbl.push_back(V(0, 1, 0, 0, 3, 1, 1, 0, 0, 0));
    // Toggle oneshot mid-run: one continuous wrap, then finish one-shot
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, i, 0, 0));
    end
    tbl.push_back(V(1, 1, 0, 0, 3, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 3; i++) begin
      tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, i, 0, 0));
    end
    tbl.push_back(V(1, 1, 0, 0, 3, 1, 0, 3, 1, 1));
    // One-shot down
    tbl.push_back(V(0, 0, 0, 0, 3, 1, 1, 3, 0, 0));
    for (int i = 2; i >= 0; i--) begin
      tbl.push_back(V(1, 0, 0, 0, 3, 1, 0, i, 0, 0));
    end
    tbl.push_back(V(1, 0, 0, 0, 3, 1, 0, 0, 1, 1));
    tbl.push_back(V(1, 0, 0, 0, 3, 1, 0, 0, 0, 1));
    tbl.push_back(V(1, 1, 1, 1, 3, 1, 0, 1, 0, 0));

    foreach (tbl[i]) drive(tbl[i]);

    // Reset mid-run at out=6 acts before the next edge
    drive(V(0, 1, 0, 0, 9, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      drive(V(1, 1, 0, 0, 9, 1, 0, i, 0, 0));
    end
    #2 rst = 1'b1;
    #1;
    chk("amid_rst_out", vidx, 32'(out), 0);
    chk("amid_rst_tc", vidx, 32'(tc), 0);
    chk("amid_rst_done", vidx, 32'(done), 0);
    #2 rst = 1'b0;
    drive(V(1, 1, 0, 0, 9, 1, 0, 0, 0, 0));
    drive(V(1, 1, 0, 0, 9, 1, 0, 0, 0, 0));

`ifdef MOD_N_UPDOWN_WRAPCNT_EN
    drive(V(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("wrap_after_load", vidx, 32'(wrap_cnt), 0);
    drive(V(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    chk("wrap_first", vidx, 32'(wrap_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      drive(V(1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      chk("wrap_cnt", vidx, 32'(wrap_cnt), (i > 3) ? 3 : i);
    end
    drive(V(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("wrap_clr", vidx, 32'(wrap_cnt), 0);
`endif

    if (sb.size() != 0) chk("scoreboard_left", vidx, 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
